// File: rtl/cache_request_arbiter.sv
// Round-robin arbiter sharing one character cache between N_REQ requesters.
// Holds each grant until the cache accepts it and steers the response back a cycle later.
module cache_request_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DWIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DWIDTH-1:0]             rsp_data,
  output logic                          cache_addr_valid,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  input  logic                          cache_addr_ready,
  input  logic [DWIDTH-1:0]             cache_data
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        grant;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        rsp_idx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rsp_pend;

  logic                    hs;
  logic [IDX_W-1:0]        grant_inc;
  logic [IDX_W-1:0]        arb_start;
  logic [IDX_W-1:0]        arb_win;
  logic [N_REQ-1:0]        arb_vec;
  logic                    arb_found;
  logic [ADDR_WIDTH-1:0]   win_addr;

  assign hs        = (state == BUSY) && cache_addr_ready;
  assign grant_inc = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);

  // On a handshake the current winner is masked and the scan restarts just after it.
  always_comb begin
    arb_vec   = req_valid;
    arb_start = ptr;
    if (hs) begin
      arb_vec[grant] = 1'b0;
      arb_start      = grant_inc;
    end
  end

  always_comb begin : rr_pick
    int unsigned s;
    s         = 0;
    arb_found = 1'b0;
    arb_win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      s = 32'(arb_start) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!arb_found && arb_vec[s]) begin
        arb_found = 1'b1;
        arb_win   = IDX_W'(s);
      end
    end
  end

  assign win_addr = req_addr[32'(arb_win)*ADDR_WIDTH +: ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      addr_q   <= '0;
      rsp_pend <= 1'b0;
      rsp_idx  <= '0;
    end else begin
      rsp_pend <= hs;
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant  <= arb_win;
            addr_q <= win_addr;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            rsp_idx <= grant;
            ptr     <= grant_inc;
            if (arb_found) begin
              grant  <= arb_win;
              addr_q <= win_addr;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready        = hs ? (N_REQ'(1) << grant) : '0;
  assign rsp_valid        = rsp_pend ? (N_REQ'(1) << rsp_idx) : '0;
  assign rsp_data         = rsp_pend ? cache_data : '0;
  assign cache_addr_valid = (state == BUSY);
  assign cache_addr       = addr_q;

endmodule

// File: doc/cache_request_arbiter.md
# cache_request_arbiter

Round-robin arbiter that shares one direct-mapped character cache between `N_REQ` requesters, such as regex engine cores fetching input characters. It sits between the requesters and the cache's `addr_in` handshake and holds each grant until the cache accepts the address. This covers hits and arbitrarily long misses. It routes the cache's `data_out` back to the winner one cycle after acceptance. Hits from different requesters are sustained back-to-back at one access per cycle.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 16: word address width, equal to the cache's `ADDR_IN_WIDTH`.
- `DWIDTH`, 8: data word width, equal to the cache's `DWIDTH`.
- `IDX_W`, $clog2(N_REQ): grant index width (derived, not overridden).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request.
- `req_addr` in N_REQ*ADDR_WIDTH: requester i's address is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready` out N_REQ: one-hot pulse in the cycle the cache accepts requester i's address.
- `rsp_valid` out N_REQ: one-hot pulse, one cycle after `req_ready[i]`.
- `rsp_data` out DWIDTH: shared response bus; valid only while some `rsp_valid` bit is high.
- `cache_addr_valid` out 1: drives the cache's `addr_in_valid`.
- `cache_addr` out ADDR_WIDTH: drives the cache's `addr_in`.
- `cache_addr_ready` in 1: from the cache's `addr_in_ready`.
- `cache_data` in DWIDTH: from the cache's `data_out`; valid the cycle after the handshake.

## Operation
- **Requester protocol:** once `req_valid[i]` is high, it stays high with `req_addr` stable until `req_ready[i]`. Withdrawing early is a protocol violation; the arbiter does not detect it and completes the grant anyway.
- **Registers:**
  - `state` ∈ {IDLE, BUSY}
  - `grant` (IDX_W bits)
  - `ptr` (IDX_W bits, round-robin start point)
  - `addr_q` (ADDR_WIDTH bits)
  - `rsp_pend` (1 bit)
  - `rsp_idx` (IDX_W bits)
- **IDLE:**
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, … modulo N_REQ.
  - Register the winner into `grant`, register its address into `addr_q`, and go to BUSY.
- **BUSY:**
  - `cache_addr_valid`=1 and `cache_addr`=`addr_q`, both driven from registers.
  - Without `cache_addr_ready`, hold `grant` and `addr_q` unchanged for as many cycles as the cache takes (miss refill).
- **Handshake** (BUSY and `cache_addr_ready`=1):
  - Drive `req_ready[grant]`=1 combinationally.
  - Set `rsp_pend`=1 and `rsp_idx`=`grant`.
  - Set `ptr`=`grant`+1 mod N_REQ.
  - Re-arbitrate in the same cycle over `req_valid` with bit `grant` masked, scanning from `grant`+1.
  - If there is a winner, stay in BUSY with the new `grant`/`addr_q`. If not, go to IDLE.
- **Response:** when `rsp_pend`=1, `rsp_valid[rsp_idx]`=1 and `rsp_data`=`cache_data`, passed through combinationally. `rsp_pend` clears unless a new handshake occurs in the same cycle.
- **Non-power-of-two N_REQ:** the modulo wrap must handle it; `ptr` never holds a value ≥ N_REQ.
- **Reset** (`rst`=0, asynchronous, any time including mid-miss):
  - state=IDLE, ptr=0, grant=0, addr_q=0, rsp_pend=0.
  - All outputs 0 immediately.
  - An in-flight cache transaction is abandoned; the cache shares `rst` and is reset with the arbiter.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0 (gated by `rsp_pend`), `cache_addr_valid`=0, `cache_addr`=0.
- **Request to cache:** `req_valid` is sampled at edge k and `cache_addr_valid` rises after edge k (IDLE→BUSY takes one cycle).
- **Cache acceptance:** the arbiter tolerates any cache latency ≥0 cycles from `cache_addr_valid` to `cache_addr_ready`.
- **Response latency:** `rsp_valid[i]` is high exactly one cycle after `req_ready[i]`.
- **Throughput:** with hits and distinct waiting requesters, one access per cycle and no bubbles.
- **Same requester back-to-back:** one IDLE bubble between consecutive accesses by the same requester.
- **Overlap:** `rsp_valid` for access n may coincide with `req_ready` for access n+1, to a different requester.
- **Fairness bound:** a requester waits at most N_REQ-1 grants.

## Test plan
- **Single hit:** after reset, `req_valid[0]`=1, addr 0xEAD0; cache model asserts ready one cycle after valid, data 0xF. Required: `cache_addr`=0xEAD0, one `req_ready[0]` pulse, `rsp_valid[0]` the next cycle with `rsp_data`=0xF, then IDLE.
- **All four at once:** all `req_valid` rise together with addresses 0xEAD0–0xEAD3; every access hits. Required: grant order 0,1,2,3 back-to-back, `cache_addr` sequence 0xEAD0..0xEAD3 on consecutive cycles, and each `rsp_valid` one cycle after its `req_ready`.
- **Miss stall:** requester 1 misses and the cache holds ready low for 20 cycles while requester 2 is waiting. Required: `cache_addr` stable for all 20 cycles, no `req_ready` or `rsp_valid` during the stall, then requester 1 is served followed immediately by requester 2.
- **Fairness:** requesters 0 and 2 request continuously, all accesses hit. Required: grants alternate 0,2,0,2 for 16 accesses; 1 and 3 are never granted.
- **Same requester repeat:** only requester 3 requests, 4 consecutive addresses. Required: a handshake every second cycle with one IDLE cycle between accesses.
- **Reset mid-miss:** `rst`=0 while BUSY, asserted between clock edges. Required: `cache_addr_valid` and all `rsp_valid` drop with no clock edge. After release, first grant goes to the lowest requesting index, since `ptr`=0.
